// File: rtl/bsg_manycore_link_credit_tx.sv
// Credit-based transmit endpoint for a manycore forward link: accepts packets on
// valid/ready and drives a registered valid/data beat only while far-end credit remains.
module bsg_manycore_link_credit_tx #(
    parameter int width_p             = 16,
    parameter int credits_p           = 3,
    parameter int credit_cnt_width_lp = $clog2(credits_p + 1)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,

    input  logic                           v_i,
    input  logic [width_p-1:0]             data_i,
    output logic                           ready_o,

    output logic                           v_o,
    output logic [width_p-1:0]             data_o,

    input  logic                           credit_i,
    output logic [credit_cnt_width_lp-1:0] credits_avail_o,
    output logic                           all_credits_o,
    output logic                           credit_overflow_o
);

    localparam logic [credit_cnt_width_lp-1:0] credits_full_lp = credit_cnt_width_lp'(credits_p);
    localparam logic [credit_cnt_width_lp-1:0] credit_one_lp   = credit_cnt_width_lp'(1);

    logic [credit_cnt_width_lp-1:0] credit_cnt_q, credit_cnt_d;
    logic                           v_q, v_d;
    logic [width_p-1:0]             data_q, data_d;
    logic                           overflow_q, overflow_d;
    logic                           fire;
    logic                           cnt_full;

    // ready comes straight from the counter flop, so credit_i never reaches it combinationally
    assign ready_o  = (credit_cnt_q != '0);
    assign cnt_full = (credit_cnt_q == credits_full_lp);
    assign fire     = v_i & ready_o;

    always_comb begin
        v_d          = fire;
        data_d       = fire ? data_i : data_q;
        credit_cnt_d = credit_cnt_q;
        overflow_d   = overflow_q;

        case ({fire, credit_i})
            2'b10: credit_cnt_d = credit_cnt_q - credit_one_lp;
            2'b01: begin
                // A credit beyond full means the far end returned one it never owed us
                if (cnt_full) begin
                    overflow_d = 1'b1;
                end else begin
                    credit_cnt_d = credit_cnt_q + credit_one_lp;
                end
            end
            default: credit_cnt_d = credit_cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            credit_cnt_q <= credits_full_lp;
            v_q          <= 1'b0;
            data_q       <= '0;
            overflow_q   <= 1'b0;
        end else begin
            credit_cnt_q <= credit_cnt_d;
            v_q          <= v_d;
            data_q       <= data_d;
            overflow_q   <= overflow_d;
        end
    end

    assign v_o               = v_q;
    assign data_o            = data_q;
    assign credits_avail_o   = credit_cnt_q;
    assign all_credits_o     = cnt_full;
    assign credit_overflow_o = overflow_q;

endmodule

// File: tb/tb_bsg_manycore_link_credit_tx.sv
// Directed bench for bsg_manycore_link_credit_tx: a reference model pushes expected
// packets into a scoreboard on each fire, and a monitor pops them as v_o beats appear.
module tb_bsg_manycore_link_credit_tx;

   localparam int WIDTH   = 8;
   localparam int CREDITS = 3;

   logic             clk_i = 1'b0;
   logic             reset_n_i;
   logic             v_i;
   logic [WIDTH-1:0] data_i;
   logic             ready_o;
   logic             v_o;
   logic [WIDTH-1:0] data_o;
   logic             credit_i;
   logic [1:0]       credits_avail_o;
   logic             all_credits_o;
   logic             credit_overflow_o;

   logic             manualCredit = 1'b0;
   logic             farCredit = 1'b0;
   logic             farSeen = 1'b0;
   logic             farEn = 1'b0;

   int               checkCount = 0;
   int               passCount = 0;

   logic [WIDTH-1:0] scoreboard[$];
   int               mCnt = CREDITS;
   logic             mV = 1'b0;
   logic             mOvf = 1'b0;
   logic [WIDTH-1:0] mLast = '0;
   int               streak;

   assign credit_i = manualCredit | farCredit;

   bsg_manycore_link_credit_tx #(
      .width_p   (WIDTH),
      .credits_p (CREDITS)
   ) dut (
      .clk_i             (clk_i),
      .reset_n_i         (reset_n_i),
      .v_i               (v_i),
      .data_i            (data_i),
      .ready_o           (ready_o),
      .v_o               (v_o),
      .data_o            (data_o),
      .credit_i          (credit_i),
      .credits_avail_o   (credits_avail_o),
      .all_credits_o     (all_credits_o),
      .credit_overflow_o (credit_overflow_o)
   );

   // Free-running clock, 10 time-unit period
   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
   endtask

   task automatic applyStimulus(input logic rstN, input logic valid, input logic [WIDTH-1:0] data, input logic credit);
      reset_n_i    = rstN;
      v_i          = valid;
      data_i       = data;
      manualCredit = credit;
   endtask

   task automatic cycle();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   // Reference model: samples inputs on the rising edge and records every packet that should fire
   initial begin
      forever begin
         @(posedge clk_i);
         if (reset_n_i !== 1'b1) begin
            mCnt = CREDITS;
            mV = 1'b0;
            mOvf = 1'b0;
            mLast = '0;
            scoreboard.delete();
         end else begin
            mV = (v_i === 1'b1) && (mCnt != 0);
            if (mV) scoreboard.push_back(data_i);
            if (mV && credit_i !== 1'b1) mCnt = mCnt - 1;
            else if (!mV && credit_i === 1'b1) begin
               if (mCnt == CREDITS) mOvf = 1'b1;
               else mCnt = mCnt + 1;
            end
         end
      end
   end

   // Monitor: compares every output on the falling edge and drains the scoreboard on each beat
   initial begin
      forever begin
         @(negedge clk_i);
         checkOutput("mon_v_o", 32'(v_o), 32'(mV));
         checkOutput("mon_credits", 32'(credits_avail_o), 32'(mCnt));
         checkOutput("mon_ready", 32'(ready_o), 32'(mCnt != 0));
         checkOutput("mon_all_credits", 32'(all_credits_o), 32'(mCnt == CREDITS));
         checkOutput("mon_overflow", 32'(credit_overflow_o), 32'(mOvf));
         if (v_o === 1'b1) begin
            if (scoreboard.size() == 0) begin
               checkOutput("mon_unexpected_beat", 32'(data_o), 32'hFFFF_FFFF);
            end else begin
               mLast = scoreboard.pop_front();
               checkOutput("mon_data", 32'(data_o), 32'(mLast));
            end
         end else begin
            checkOutput("mon_data_hold", 32'(data_o), 32'(mLast));
         end
      end
   end

   // Far end: a beat seen in one cycle returns its credit in the following cycle
   initial begin
      forever begin
         @(negedge clk_i);
         farCredit = farSeen;
         farSeen = farEn && (v_o === 1'b1);
      end
   end

   initial begin
      // Reset held two cycles with valid and credit asserted: both must be ignored
      applyStimulus(1'b0, 1'b1, 8'h55, 1'b1);
      cycle();
      cycle();
      checkOutput("rst_v_o", 32'(v_o), 32'd0);
      checkOutput("rst_credits", 32'(credits_avail_o), 32'd3);
      checkOutput("rst_overflow", 32'(credit_overflow_o), 32'd0);
      checkOutput("rst_data_o", 32'(data_o), 32'd0);

      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      cycle();
      checkOutput("post_rst_ready", 32'(ready_o), 32'd1);
      checkOutput("post_rst_all_credits", 32'(all_credits_o), 32'd1);
      checkOutput("post_rst_v_o", 32'(v_o), 32'd0);

      // Credit exhaustion: three packets go out, the fourth waits
      applyStimulus(1'b1, 1'b1, 8'hA1, 1'b0);
      cycle();
      checkOutput("exh_a1_v", 32'(v_o), 32'd1);
      checkOutput("exh_a1_data", 32'(data_o), 32'hA1);
      checkOutput("exh_a1_cnt", 32'(credits_avail_o), 32'd2);
      applyStimulus(1'b1, 1'b1, 8'hA2, 1'b0);
      cycle();
      checkOutput("exh_a2_data", 32'(data_o), 32'hA2);
      checkOutput("exh_a2_cnt", 32'(credits_avail_o), 32'd1);
      applyStimulus(1'b1, 1'b1, 8'hA3, 1'b0);
      cycle();
      checkOutput("exh_a3_data", 32'(data_o), 32'hA3);
      checkOutput("exh_a3_cnt", 32'(credits_avail_o), 32'd0);
      checkOutput("exh_a3_ready", 32'(ready_o), 32'd0);
      applyStimulus(1'b1, 1'b1, 8'hA4, 1'b0);
      cycle();
      checkOutput("exh_a4_held_v", 32'(v_o), 32'd0);
      checkOutput("exh_a4_held_data", 32'(data_o), 32'hA3);
      cycle();
      checkOutput("exh_a4_still_held", 32'(v_o), 32'd0);
      checkOutput("exh_a4_cnt", 32'(credits_avail_o), 32'd0);

      // One credit reopens the link; A4 fires on the following edge
      applyStimulus(1'b1, 1'b1, 8'hA4, 1'b1);
      cycle();
      checkOutput("credit_ready", 32'(ready_o), 32'd1);
      checkOutput("credit_no_beat_yet", 32'(v_o), 32'd0);
      applyStimulus(1'b1, 1'b1, 8'hA4, 1'b0);
      cycle();
      checkOutput("a4_v", 32'(v_o), 32'd1);
      checkOutput("a4_data", 32'(data_o), 32'hA4);
      checkOutput("a4_cnt", 32'(credits_avail_o), 32'd0);

      // Simultaneous fire and credit at count 1 leaves the count at 1
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      cycle();
      checkOutput("sim_pre_cnt", 32'(credits_avail_o), 32'd1);
      applyStimulus(1'b1, 1'b1, 8'hB1, 1'b1);
      cycle();
      checkOutput("sim_v", 32'(v_o), 32'd1);
      checkOutput("sim_data", 32'(data_o), 32'hB1);
      checkOutput("sim_cnt", 32'(credits_avail_o), 32'd1);

      // Refill to full, then overflow with one extra credit
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      cycle();
      cycle();
      checkOutput("refill_all_credits", 32'(all_credits_o), 32'd1);
      checkOutput("refill_no_ovf", 32'(credit_overflow_o), 32'd0);
      cycle();
      checkOutput("ovf_set", 32'(credit_overflow_o), 32'd1);
      checkOutput("ovf_cnt_sat", 32'(credits_avail_o), 32'd3);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      cycle();
      cycle();
      checkOutput("ovf_sticky", 32'(credit_overflow_o), 32'd1);

      // Streaming against the far-end model: twenty back-to-back beats
      farEn = 1'b1;
      streak = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 1'b1, 8'(8'hC0 + i), 1'b0);
         cycle();
         if (v_o === 1'b1) streak++;
      end
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      cycle();
      cycle();
      cycle();
      cycle();
      farEn = 1'b0;
      checkOutput("stream_streak", 32'(streak), 32'd20);
      checkOutput("stream_drained", 32'(all_credits_o), 32'd1);
      checkOutput("stream_cnt", 32'(credits_avail_o), 32'd3);
      checkOutput("stream_sb_empty", 32'(scoreboard.size()), 32'd0);

      // Reset in the middle of traffic with count 1 and a beat on the link
      applyStimulus(1'b1, 1'b1, 8'hD1, 1'b0);
      cycle();
      applyStimulus(1'b1, 1'b1, 8'hD2, 1'b0);
      cycle();
      checkOutput("mid_pre_v", 32'(v_o), 32'd1);
      checkOutput("mid_pre_cnt", 32'(credits_avail_o), 32'd1);
      applyStimulus(1'b0, 1'b1, 8'hD3, 1'b0);
      cycle();
      checkOutput("mid_rst_v", 32'(v_o), 32'd0);
      checkOutput("mid_rst_cnt", 32'(credits_avail_o), 32'd3);
      checkOutput("mid_rst_ovf_clear", 32'(credit_overflow_o), 32'd0);
      applyStimulus(1'b1, 1'b1, 8'hE1, 1'b0);
      cycle();
      checkOutput("resume_v", 32'(v_o), 32'd1);
      checkOutput("resume_data", 32'(data_o), 32'hE1);
      checkOutput("resume_cnt", 32'(credits_avail_o), 32'd2);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      cycle();
      checkOutput("final_sb_empty", 32'(scoreboard.size()), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
